// File: rtl/dcache_wb.sv
// ============================================================================
// Module   : dcache_wb
// Brief    : Direct-mapped, one-word-line, write-back data cache with halt flush.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dcache_wb #(
   parameter int SETS = 16
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        dmemREN,
   input  logic        dmemWEN,
   input  logic [31:0] dmemaddr,
   input  logic [31:0] dmemstore,
   input  logic        halt,
   output logic        dhit,
   output logic [31:0] dmemload,
   output logic        flushed,
   output logic        dREN,
   output logic        dWEN,
   output logic [31:0] daddr,
   output logic [31:0] dstore,
   input  logic        dwait,
   input  logic [31:0] dload
);

   localparam int IW = $clog2(SETS);
   localparam int TW = 30 - IW;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_WB    = 3'd1;
   localparam logic [2:0] S_FILL  = 3'd2;
   localparam logic [2:0] S_FLUSH = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   localparam logic [IW-1:0] C_LAST = IW'(SETS - 1);

   logic [2:0]      state_q, state_d;
   logic [SETS-1:0] valid_q, valid_d;
   logic [SETS-1:0] dirty_q, dirty_d;
   logic [IW-1:0]   fidx_q, fidx_d;
   logic            hpend_q, hpend_d;
   logic [TW-1:0]   tag_q  [SETS];
   logic [31:0]     data_q [SETS];

   logic [IW-1:0] w_idx;
   logic [TW-1:0] w_tag;
   logic          w_req;
   logic          w_halt;
   logic          w_match;
   logic          w_lookup;
   logic          w_fill_done;
   logic          w_unused;

   assign w_idx       = dmemaddr[IW+1:2];
   assign w_tag       = dmemaddr[31:IW+2];
   assign w_req       = dmemREN | dmemWEN;
   // A halt seen during a transfer is remembered so a one-cycle pulse still flushes.
   assign w_halt      = halt | hpend_q;
   assign w_match     = valid_q[w_idx] && (tag_q[w_idx] == w_tag);
   assign w_lookup    = (state_q == S_IDLE) && w_req && !w_halt && w_match;
   assign w_fill_done = (state_q == S_FILL) && !dwait;
   assign w_unused    = ^dmemaddr[1:0];

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= S_IDLE;
         valid_q <= '0;
         dirty_q <= '0;
         fidx_q  <= '0;
         hpend_q <= 1'b0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         dirty_q <= dirty_d;
         fidx_q  <= fidx_d;
         hpend_q <= hpend_d;
      end
   end

   // Tag/data storage needs no reset: valid bits gate every use.
   always_ff @(posedge CLK) begin
      if (w_lookup && dmemWEN) begin
         data_q[w_idx] <= dmemstore;
      end else if (w_fill_done) begin
         data_q[w_idx] <= dload;
         tag_q[w_idx]  <= w_tag;
      end
   end

   always_comb begin
      state_d = state_q;
      valid_d = valid_q;
      dirty_d = dirty_q;
      fidx_d  = fidx_q;
      hpend_d = hpend_q;
      case (state_q)
         S_IDLE: begin
            if (w_halt) begin
               state_d = S_FLUSH;
               fidx_d  = '0;
               hpend_d = 1'b0;
            end else if (w_req) begin
               if (w_match) begin
                  if (dmemWEN) dirty_d[w_idx] = 1'b1;
               end else if (valid_q[w_idx] && dirty_q[w_idx]) begin
                  state_d = S_WB;
               end else begin
                  state_d = S_FILL;
               end
            end
         end
         S_WB: begin
            if (halt) hpend_d = 1'b1;
            if (!dwait) begin
               dirty_d[w_idx] = 1'b0;
               state_d        = S_FILL;
            end
         end
         S_FILL: begin
            if (halt) hpend_d = 1'b1;
            if (!dwait) begin
               valid_d[w_idx] = 1'b1;
               dirty_d[w_idx] = 1'b0;
               state_d        = S_IDLE;
            end
         end
         S_FLUSH: begin
            if (!dirty_q[fidx_q] || !dwait) begin
               dirty_d[fidx_q] = 1'b0;
               if (fidx_q == C_LAST) state_d = S_DONE;
               else                  fidx_d  = fidx_q + 1'b1;
            end
         end
         S_DONE:  state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      dhit     = 1'b0;
      dmemload = '0;
      flushed  = 1'b0;
      dREN     = 1'b0;
      dWEN     = 1'b0;
      daddr    = '0;
      dstore   = '0;
      case (state_q)
         S_IDLE: begin
            if (w_lookup) begin
               dhit     = 1'b1;
               dmemload = data_q[w_idx];
            end
         end
         S_WB: begin
            dWEN   = 1'b1;
            daddr  = {tag_q[w_idx], w_idx, 2'b00};
            dstore = data_q[w_idx];
         end
         S_FILL: begin
            dREN  = 1'b1;
            daddr = {dmemaddr[31:2], 2'b00};
         end
         S_FLUSH: begin
            if (dirty_q[fidx_q]) begin
               dWEN   = 1'b1;
               daddr  = {tag_q[fidx_q], fidx_q, 2'b00};
               dstore = data_q[fidx_q];
            end
         end
         S_DONE:  flushed = 1'b1;
         default: flushed = 1'b0;
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_dcache_wb.sv
// ============================================================================
// Module   : tb_dcache_wb
// Brief    : Self-checking bench for dcache_wb against a golden-memory model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_dcache_wb;

   localparam int SETS = 16;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        dmemREN, dmemWEN, halt, dwait;
   logic [31:0] dmemaddr, dmemstore, dload;
   logic        dhit, flushed, dREN, dWEN;
   logic [31:0] dmemload, daddr, dstore;

   dcache_wb #(.SETS(SETS)) dut (
      .CLK(CLK), .nRST(nRST), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
      .dmemaddr(dmemaddr), .dmemstore(dmemstore), .halt(halt),
      .dhit(dhit), .dmemload(dmemload), .flushed(flushed),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .dwait(dwait), .dload(dload)
   );

   always #5 CLK = ~CLK;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h want %08h", nm, act, exp);
      end
   endtask

   // Backing memory, datapath-visible golden image, and transfer log
   logic [31:0] mem    [1024];
   logic [31:0] golden [1024];
   int          lat = 0;
   int          cnt = 0;
   bit          lg_w [$];
   logic [31:0] lg_a [$];
   logic [31:0] lg_d [$];

   // Cache residency model: which word each index holds and whether it is dirty
   bit          mvalid [SETS];
   bit          mdirty [SETS];
   logic [29:0] mres   [SETS];

   always @(negedge CLK) begin
      if (!nRST) begin
         cnt   = 0;
         dwait = 1'b1;
      end else if (dREN || dWEN) begin
         if (cnt >= lat) begin
            dwait = 1'b0;
            cnt   = 0;
            lg_w.push_back(dWEN);
            lg_a.push_back(daddr);
            lg_d.push_back(dWEN ? dstore : mem[daddr[11:2]]);
            if (dWEN) mem[daddr[11:2]] = dstore;
            else      dload = mem[daddr[11:2]];
         end else begin
            dwait = 1'b1;
            cnt++;
         end
      end else begin
         dwait = 1'b1;
         cnt   = 0;
      end
   end

   always @(negedge CLK) begin
      #2;
      if (nRST) begin
         chk("rd_wr_exclusive", 32'(dREN & dWEN), 32'd0);
         if (dREN) chk("fill_addr_word", daddr, {dmemaddr[31:2], 2'b00});
         if (dWEN) chk("wb_addr_align", 32'(daddr[1:0]), 32'd0);
         if (dhit && dmemREN && !dmemWEN)
            chk("load_vs_golden", dmemload, golden[dmemaddr[11:2]]);
         if (flushed) chk("done_quiet", 32'({dhit, dREN, dWEN}), 32'd0);
         if (!dmemREN && !dmemWEN && !halt)
            chk("no_req_quiet", 32'({dhit, dREN, dWEN}), 32'd0);
      end
   end

   task automatic model_reset();
      for (int i = 0; i < SETS; i++) begin
         mvalid[i] = 1'b0;
         mdirty[i] = 1'b0;
      end
      for (int i = 0; i < 1024; i++) golden[i] = mem[i];
   endtask

   task automatic access(input bit we, input bit both, input logic [31:0] a,
                         input logic [31:0] d, output logic [31:0] got, output int waited);
      int          idx, n0, ne;
      logic [29:0] w, vres;
      bit          hit, vd;
      idx  = int'(a[5:2]);
      w    = a[31:2];
      hit  = mvalid[idx] && (mres[idx] == w);
      vd   = mvalid[idx] && mdirty[idx];
      vres = mres[idx];
      n0   = lg_w.size();
      @(negedge CLK);
      dmemaddr  = a;
      dmemstore = d;
      dmemWEN   = we;
      dmemREN   = !we || both;
      waited    = 0;
      got       = '0;
      while (1) begin
         #1;
         if (dhit) break;
         if (waited >= 400) begin
            chk("access_timeout", 32'(waited), 32'd0);
            break;
         end
         @(negedge CLK);
         waited++;
      end
      got = dmemload;
      @(posedge CLK);
      #1;
      dmemREN = 1'b0;
      dmemWEN = 1'b0;
      ne = hit ? 0 : (vd ? 2 : 1);
      chk("xfer_count", 32'(lg_w.size() - n0), 32'(ne));
      if ((lg_w.size() - n0 == ne) && ne > 0) begin
         if (ne == 2) begin
            chk("victim_we", 32'(lg_w[n0]), 32'd1);
            chk("victim_addr", lg_a[n0], {vres, 2'b00});
            chk("victim_data", lg_d[n0], golden[vres[9:0]]);
         end
         chk("fill_we", 32'(lg_w[n0+ne-1]), 32'd0);
         chk("fill_addr", lg_a[n0+ne-1], {w, 2'b00});
      end
      if (!we) chk("load_value", got, golden[w[9:0]]);
      if (hit) chk("hit_zero_wait", 32'(waited), 32'd0);
      mvalid[idx] = 1'b1;
      mres[idx]   = w;
      if (!hit) mdirty[idx] = 1'b0;
      if (we) begin
         mdirty[idx]    = 1'b1;
         golden[w[9:0]] = d;
      end
   endtask

   task automatic do_flush();
      int n0, k, w, bad;
      n0   = lg_w.size();
      halt = 1'b1;
      w    = 0;
      while (!flushed && w < 600) begin
         @(negedge CLK);
         #1;
         w++;
      end
      chk("flush_reached", 32'(flushed), 32'd1);
      k = n0;
      for (int i = 0; i < SETS; i++) begin
         if (mvalid[i] && mdirty[i]) begin
            if (k < lg_w.size()) begin
               chk("flush_we", 32'(lg_w[k]), 32'd1);
               chk("flush_addr", lg_a[k], {mres[i], 2'b00});
               chk("flush_data", lg_d[k], golden[mres[i][9:0]]);
            end
            k++;
         end
      end
      chk("flush_count", 32'(lg_w.size() - n0), 32'(k - n0));
      repeat (4) begin
         @(negedge CLK);
         dmemREN  = 1'b1;
         dmemaddr = 32'h40;
         #1;
         chk("flushed_held", 32'(flushed), 32'd1);
      end
      @(negedge CLK);
      dmemREN = 1'b0;
      halt    = 1'b0;
      #1;
      chk("flushed_after_halt_low", 32'(flushed), 32'd1);
      bad = 0;
      for (int i = 0; i < 1024; i++) if (mem[i] !== golden[i]) bad++;
      chk("mem_image", 32'(bad), 32'd0);
      for (int i = 0; i < SETS; i++) mdirty[i] = 1'b0;
   endtask

   task automatic rst_checks(input string tag);
      chk({tag, "_dhit"},     32'(dhit),    32'd0);
      chk({tag, "_flushed"},  32'(flushed), 32'd0);
      chk({tag, "_dREN"},     32'(dREN),    32'd0);
      chk({tag, "_dWEN"},     32'(dWEN),    32'd0);
      chk({tag, "_daddr"},    daddr,        32'd0);
      chk({tag, "_dstore"},   dstore,       32'd0);
      chk({tag, "_dmemload"}, dmemload,     32'd0);
   endtask

   task automatic do_reset();
      @(negedge CLK);
      #2;
      nRST    = 1'b0;
      dmemREN = 1'b0;
      dmemWEN = 1'b0;
      halt    = 1'b0;
      #1;
      rst_checks("rst");
      @(negedge CLK);
      #2;
      nRST = 1'b1;
      model_reset();
   endtask

   logic [31:0] got;
   int          wt, n0, b;

   initial begin
      nRST = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0; halt = 1'b0;
      dmemaddr = '0; dmemstore = '0; dwait = 1'b1; dload = '0;
      for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 | 32'(i);
      mem[16] = 32'hDEADBEEF;
      model_reset();
      repeat (2) @(negedge CLK);
      #1;
      rst_checks("por");
      @(negedge CLK);
      #2;
      nRST = 1'b1;

      // Cold load: 3 wait cycles, hit 5 negedges after the request
      lat = 3;
      n0  = lg_w.size();
      access(1'b0, 1'b0, 32'h40, 32'h0, got, wt);
      chk("cold_load_data", got, 32'hDEADBEEF);
      chk("cold_load_cycles", 32'(wt), 32'd5);
      if (lg_a.size() > n0) chk("cold_fill_daddr", lg_a[n0], 32'h40);

      // Store hit, then reload
      access(1'b1, 1'b0, 32'h40, 32'h11, got, wt);
      chk("store_hit_cycles", 32'(wt), 32'd0);
      access(1'b0, 1'b0, 32'h40, 32'h0, got, wt);
      chk("reload_value", got, 32'h11);

      // Conflict miss on index 0 with a dirty victim
      n0 = lg_w.size();
      access(1'b0, 1'b0, 32'h440, 32'h0, got, wt);
      if (lg_w.size() >= n0 + 2) begin
         chk("conflict_wb_we",    32'(lg_w[n0]), 32'd1);
         chk("conflict_wb_addr",  lg_a[n0],      32'h40);
         chk("conflict_wb_data",  lg_d[n0],      32'h11);
         chk("conflict_fill_addr", lg_a[n0+1],   32'h440);
      end else begin
         chk("conflict_xfers", 32'(lg_w.size() - n0), 32'd2);
      end

      // Mixed patterns at other latencies
      lat = 0;
      access(1'b1, 1'b1, 32'h80, 32'hCAFE0000, got, wt);
      lat = 1;
      access(1'b1, 1'b0, 32'h14, 32'h55, got, wt);
      access(1'b0, 1'b0, 32'h14, 32'h0, got, wt);
      access(1'b0, 1'b0, 32'h0, 32'h0, got, wt);
      access(1'b1, 1'b0, 32'h58, 32'h66, got, wt);
      lat = 2;
      access(1'b0, 1'b0, 32'h98, 32'h0, got, wt);
      repeat (3) @(negedge CLK);

      // Flush of dirty sets 0 and 5
      do_reset();
      lat = 1;
      access(1'b1, 1'b0, 32'h0, 32'h1234, got, wt);
      access(1'b1, 1'b0, 32'h14, 32'h5678, got, wt);
      n0 = lg_w.size();
      do_flush();
      chk("flush2_count", 32'(lg_w.size() - n0), 32'd2);
      if (lg_w.size() >= n0 + 2) begin
         chk("flush2_first",  lg_a[n0],   32'h0);
         chk("flush2_second", lg_a[n0+1], 32'h14);
      end

      // Halt raised mid-fill
      do_reset();
      lat = 4;
      access(1'b1, 1'b0, 32'h40, 32'h22, got, wt);
      access(1'b1, 1'b0, 32'h8, 32'h33, got, wt);
      n0 = lg_w.size();
      @(negedge CLK);
      dmemaddr = 32'h440;
      dmemREN  = 1'b1;
      b = 0;
      do begin
         @(negedge CLK);
         #1;
         b++;
      end while (!dREN && b < 200);
      chk("fill_seen", 32'(dREN), 32'd1);
      @(negedge CLK);
      halt = 1'b1;
      #1;
      chk("halt_during_fill_dwait", 32'(dwait), 32'd1);
      b = 0;
      while (dREN && b < 200) begin
         @(negedge CLK);
         #1;
         b++;
      end
      chk("halt_fill_xfers", 32'(lg_w.size() - n0), 32'd2);
      if (lg_w.size() >= n0 + 2) begin
         chk("halt_wb_addr",   lg_a[n0],   32'h40);
         chk("halt_wb_data",   lg_d[n0],   32'h22);
         chk("halt_fill_addr", lg_a[n0+1], 32'h440);
      end
      mres[0]   = 30'h110;
      mvalid[0] = 1'b1;
      mdirty[0] = 1'b0;
      do_flush();
      chk("halt_total_xfers", 32'(lg_w.size() - n0), 32'd3);
      if (lg_w.size() >= n0 + 3) chk("halt_flush_addr", lg_a[n0+2], 32'h8);

      // Reset pulse during write-back
      do_reset();
      lat = 1;
      access(1'b1, 1'b0, 32'h40, 32'h44, got, wt);
      lat = 50;
      @(negedge CLK);
      dmemaddr = 32'h440;
      dmemREN  = 1'b1;
      b = 0;
      do begin
         @(negedge CLK);
         #1;
         b++;
      end while (!dWEN && b < 200);
      chk("wb_seen", 32'(dWEN), 32'd1);
      @(negedge CLK);
      #2;
      nRST = 1'b0;
      #1;
      chk("rst_drops_dWEN", 32'(dWEN), 32'd0);
      chk("rst_drops_dREN", 32'(dREN), 32'd0);
      @(negedge CLK);
      #2;
      nRST    = 1'b1;
      dmemREN = 1'b0;
      model_reset();
      lat = 1;
      n0  = lg_w.size();
      access(1'b0, 1'b0, 32'h40, 32'h0, got, wt);
      chk("post_rst_miss_xfers", 32'(lg_w.size() - n0), 32'd1);
      chk("post_rst_value", got, 32'h22);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
